// File: rtl/curve25519_host.sv
// Byte-serial host front end for a curve25519 scalar-multiplication core.
// Loads scalar and point, clamps/masks them, starts the core and streams the result back.
module curve25519_host #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         error,
  output logic         core_start,
  output logic [254:0] core_n,
  output logic [254:0] core_q,
  input  logic         core_done,
  input  logic [254:0] core_out
);

  typedef enum logic [2:0] {
    ST_LOAD_N,
    ST_LOAD_Q,
    ST_START,
    ST_WAIT,
    ST_SEND
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t               state, state_next;
  logic [4:0]           idx;
  logic [255:0]         result;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 in_xfer, out_xfer, last_byte, timed_out;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_byte = (idx == 5'd31);
  assign timed_out = TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !core_done;
  assign out_data  = result[{idx, 3'b000} +: 8];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_LOAD_N;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD_N: if (in_xfer && last_byte) state_next = ST_LOAD_Q;
      ST_LOAD_Q: if (in_xfer && last_byte) state_next = ST_START;
      ST_START:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (core_done)      state_next = ST_SEND;
        else if (timed_out) state_next = ST_LOAD_N;
      end
      ST_SEND:   if (out_xfer && last_byte) state_next = ST_LOAD_N;
      default:   state_next = ST_LOAD_N;
    endcase
  end

  // Handshake outputs decode only the registered state, so valid never depends on ready.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    core_start = 1'b0;
    case (state)
      ST_LOAD_N, ST_LOAD_Q: in_ready = 1'b1;
      ST_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
      end
      ST_WAIT:  busy      = 1'b1;
      ST_SEND:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: operand and result registers are reset as well, so no key material survives a reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      wait_cnt <= '0;
      error    <= 1'b0;
      core_n   <= '0;
      core_q   <= '0;
      result   <= '0;
    end else begin
      case (state)
        ST_LOAD_N: if (in_xfer) begin
          idx <= idx + 5'd1;  // wraps to 0 after byte 31
          if (idx == 5'd0)    core_n[7:0]     <= {in_data[7:3], 3'b000};
          else if (last_byte) core_n[254:248] <= {1'b1, in_data[5:0]};
          else                core_n[{idx, 3'b000} +: 8] <= in_data;
        end
        ST_LOAD_Q: if (in_xfer) begin
          idx <= idx + 5'd1;
          if (last_byte) core_q[254:248] <= in_data[6:0];
          else           core_q[{idx, 3'b000} +: 8] <= in_data;
        end
        ST_START: begin
          idx      <= '0;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (core_done) begin
            result <= {1'b0, core_out};
            idx    <= '0;
          end else begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            if (timed_out) error <= 1'b1;
          end
        end
        ST_SEND: if (out_xfer) idx <= idx + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_curve25519_host.sv
// Scoreboard bench for curve25519_host with a mock core; stimulus pushes expectations,
// a negedge monitor pops them at core_start and checks operands, latency and result bytes.
module tb_curve25519_host;

  localparam int TMO = 10;

  logic         clock     = 1'b0;
  logic         reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic [7:0]   in_data   = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy, error, core_start;
  logic [7:0]   out_data;
  logic [254:0] core_n, core_q;
  logic         core_done = 1'b1;
  logic [254:0] core_out  = '0;

  curve25519_host #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .error(error), .core_start(core_start),
    .core_n(core_n), .core_q(core_q), .core_done(core_done), .core_out(core_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [254:0] n;
    logic [254:0] q;
    logic [255:0] res;
    bit           timeout;
    int           busy_cycles;
  } exp_t;

  typedef enum {M_IDLE, M_WAIT, M_SEND} mon_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   mock_lat = 3;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mock core: point 9 yields a scrambled scalar, any other point is echoed back.
  function automatic logic [254:0] mock_fn(input logic [254:0] n, input logic [254:0] q);
    if (q == 255'd9) return {n[246:0], n[254:247]} ^ 255'h5a5a_c3c3;
    return q;
  endfunction

  int           mock_cnt = 0;
  logic [254:0] mock_pend = '0;
  always @(posedge clock) begin
    if (core_start) begin
      core_done <= 1'b0;
      mock_cnt  <= mock_lat;
      mock_pend <= mock_fn(core_n, core_q);
    end else if (!core_done) begin
      if (mock_cnt > 1) mock_cnt <= mock_cnt - 1;
      else begin
        core_done <= 1'b1;
        core_out  <= mock_pend;
      end
    end
  end

  // Reference model: raw little-endian bytes -> clamped operands and expected core response.
  function automatic exp_t model(input logic [255:0] s, input logic [255:0] p,
                                 input int lat, input bit to);
    exp_t e;
    logic [255:0] sv;
    sv = s;
    sv[2:0] = 3'b000;
    sv[254] = 1'b1;
    e.n = sv[254:0];
    e.q = p[254:0];
    e.res = {1'b0, mock_fn(e.n, e.q)};
    e.timeout = to;
    // START cycle plus WAIT cycles; the mock raises done lat+1 cycles after START
    e.busy_cycles = to ? TMO + 1 : lat + 2;
    return e;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bytes(input logic [255:0] v, input int nbytes, input bit rnd);
    int k = 0;
    int guard = 0;
    while (k < nbytes && guard < 1000) begin
      tick();
      in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? v[8*k +: 8] : 8'($urandom);
      @(negedge clock);
      if (in_valid && in_ready) k++;
      guard++;
    end
    tick();
    in_valid = 1'b0;
    if (k < nbytes) check("load_bound", k, nbytes);
  endtask

  task automatic drain(input int stop_at, input bit stall10);
    int n = 0;
    int guard = 0;
    int stall = 0;
    while (n < stop_at && guard < 3000) begin
      tick();
      in_valid = busy;
      in_data  = 8'($urandom);
      if (stall10 && n == 10 && out_valid && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clock);
      if (out_valid && out_ready) n++;
      guard++;
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (n < stop_at) check("drain_bound", n, stop_at);
    if (stall10) check("stall_cycles", stall, 5);
  endtask

  task automatic run_op(input logic [255:0] s, input logic [255:0] p, input int lat,
                        input bit rnd_in, input bit stall10, output logic [255:0] res);
    exp_t e;
    mock_lat = lat;
    e = model(s, p, lat, 1'b0);
    sb.push_back(e);
    send_bytes(s, 32, rnd_in);
    send_bytes(p, 32, rnd_in);
    drain(32, stall10);
    res = e.res;
  endtask

  task automatic do_reset(input string tag);
    tick();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check({tag, "_in_ready"},   in_ready,   1);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_error"},      error,      0);
    check({tag, "_core_n"},     core_n,     0);
    check({tag, "_core_q"},     core_q,     0);
    check({tag, "_out_data"},   out_data,   0);
  endtask

  initial begin : monitor
    mon_t ph = M_IDLE;
    exp_t cur;
    int   bc = 0;
    int   bi = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ph = M_IDLE;
        continue;
      end
      if (busy || out_valid) check("in_ready_blocked", in_ready, 0);
      case (ph)
        M_IDLE: begin
          check("out_valid_idle", out_valid, 0);
          if (core_start) begin
            if (sb.size() == 0) check("unexpected_start", core_start, 0);
            else begin
              cur = sb.pop_front();
              check("core_n", core_n, cur.n);
              check("core_q", core_q, cur.q);
              check("busy_start", busy, 1);
              bc = 1;
              ph = M_WAIT;
            end
          end
        end
        M_WAIT: begin
          check("core_start_pulse", core_start, 0);
          if (busy) bc++;
          else begin
            check("busy_cycles", bc, cur.busy_cycles);
            check("out_valid_after_wait", out_valid, !cur.timeout);
            if (cur.timeout) begin
              check("error_timeout", error, 1);
              ph = M_IDLE;
            end else begin
              ph = M_SEND;
              bi = 0;
            end
          end
        end
        default: ;
      endcase
      if (ph == M_SEND) begin
        if (!out_valid) begin
          check("out_valid_send", out_valid, 1);
          ph = M_IDLE;
        end else begin
          check($sformatf("out_byte%0d", bi), out_data, cur.res[8*bi +: 8]);
          if (out_ready) begin
            bi++;
            if (bi == 32) ph = M_IDLE;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [255:0] s, p, res, clamp_s, nine;
    exp_t e;
    int guard;

    nine = 256'd9;
    do_reset("init");

    // Key pair: zero scalar with base point.
    run_op('0, nine, 3, 1'b0, 1'b0, res);

    // Clamp vector: 0x27, 0x1f..0x02, 0xc0.
    clamp_s = '0;
    clamp_s[7:0] = 8'h27;
    for (int k = 1; k <= 30; k++) clamp_s[8*k +: 8] = 8'(8'h20 - k);
    clamp_s[255:248] = 8'hc0;
    run_op(clamp_s, nine, 2, 1'b0, 1'b0, res);

    // Shared secret: previous result fed back as the point.
    run_op(clamp_s, res, 4, 1'b0, 1'b0, res);

    // Echo with top point bit set: it must be masked off.
    p = rand256();
    p[255:248] = 8'hff;
    run_op(rand256(), p, 1, 1'b0, 1'b0, res);
    check("echo_byte31", res[255:248], 8'h7f);

    // Backpressure at byte 10 with ragged input valid.
    run_op(rand256(), nine, 5, 1'b1, 1'b1, res);

    // Random operations; latency 9 puts done on the last WAIT cycle before timeout.
    for (int i = 0; i < 6; i++) begin
      p = ($urandom_range(0, 1) != 0) ? nine : rand256();
      run_op(rand256(), p, (i == 0) ? 9 : $urandom_range(1, 8), 1'b1, 1'b0, res);
    end

    // Timeout: core stays busy far beyond the WAIT budget.
    mock_lat = 60000;
    s = rand256();
    e = model(s, nine, 0, 1'b1);
    sb.push_back(e);
    send_bytes(s, 32, 1'b0);
    send_bytes(nine, 32, 1'b0);
    guard = 0;
    while (!error && guard < 200) begin
      tick();
      in_valid = busy;
      in_data  = 8'($urandom);
      @(negedge clock);
      guard++;
    end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("timeout_error", error, 1);
    check("timeout_in_ready", in_ready, 1);
    check("timeout_busy", busy, 0);
    check("timeout_out_valid", out_valid, 0);

    // Error stays sticky through a good operation.
    run_op(rand256(), nine, 3, 1'b0, 1'b0, res);
    @(negedge clock);
    check("error_sticky", error, 1);
    do_reset("clear_err");

    // Reset in LOAD_Q at byte 17.
    send_bytes(rand256(), 32, 1'b0);
    send_bytes(rand256(), 17, 1'b0);
    do_reset("rst_loadq");

    // Reset in WAIT.
    mock_lat = 50;
    s = rand256();
    sb.push_back(model(s, nine, 50, 1'b0));
    send_bytes(s, 32, 1'b0);
    send_bytes(nine, 32, 1'b0);
    repeat (3) tick();
    check("rst_wait_busy_before", busy, 1);
    do_reset("rst_wait");

    // Reset in SEND at byte 5.
    mock_lat = 2;
    s = rand256();
    sb.push_back(model(s, nine, 2, 1'b0));
    send_bytes(s, 32, 1'b0);
    send_bytes(nine, 32, 1'b0);
    drain(5, 1'b0);
    check("rst_send_valid_before", out_valid, 1);
    do_reset("rst_send");

    // Fresh full operation after the mid-operation resets.
    run_op(clamp_s, nine, 6, 1'b1, 1'b0, res);

    repeat (5) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
